// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// The optional MULDIV_SIGNED_EN build adds signed operations and the FIX state.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;
    localparam int   OP_SIGNED_BIT = 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_e;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/muldiv_iter_core.sv
// One shift-add multiply or restoring divide step.
// The step is purely combinational and is applied once per cycle by the sequencer.
module muldiv_iter_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   acc_hi_i,
    input  logic [WIDTH-1:0] acc_lo_i,
    input  logic [WIDTH-1:0] operand_i,
    input  logic             op_i,
    output logic [WIDTH:0]   acc_hi_o,
    output logic [WIDTH-1:0] acc_lo_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] diff;

    // Multiply keeps the multiplier in the low half; divide keeps the
    // quotient there and shifts the remainder in from its top bit.
    always_comb begin
        sum       = acc_hi_i + (acc_lo_i[0] ? {1'b0, operand_i} : '0);
        rem_shift = {acc_hi_i[WIDTH-1:0], acc_lo_i[WIDTH-1]};
        diff      = rem_shift - {1'b0, operand_i};
        acc_hi_o  = '0;
        acc_lo_o  = '0;
        q_bit_o   = 1'b0;
        if (op_i == OP_MUL) begin
            acc_hi_o = {1'b0, sum[WIDTH:1]};
            acc_lo_o = {sum[0], acc_lo_i[WIDTH-1:1]};
        end else begin
            q_bit_o  = (rem_shift >= {1'b0, operand_i});
            acc_hi_o = q_bit_o ? diff : rem_shift;
            acc_lo_o = {acc_lo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle HI/LO controller for multu/divu/mfhi/mflo with datapath stall.
// Define MULDIV_SIGNED_EN to add signed mult/div with a sign-fixup (FIX) state.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mf_req,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   core_hi;
    logic [WIDTH-1:0] core_lo;
    logic             core_qbit;
    logic [WIDTH-1:0] iter_lo;
    logic [WIDTH-1:0] a_mag, b_mag;

`ifdef MULDIV_SIGNED_EN
    logic             sgn_q, sgn_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             a_neg, b_neg;
    logic [2*WIDTH-1:0] prod;

    assign a_neg = op[OP_SIGNED_BIT] & src_a[WIDTH-1];
    assign b_neg = op[OP_SIGNED_BIT] & src_b[WIDTH-1];
    assign a_mag = a_neg ? -src_a : src_a;
    assign b_mag = b_neg ? -src_b : src_b;
    assign prod  = {acc_hi_q[WIDTH-1:0], acc_lo_q};
`else
    logic unused_sign;
    assign unused_sign = op[OP_SIGNED_BIT];
    assign a_mag = src_a;
    assign b_mag = src_b;
`endif

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .acc_hi_i  (acc_hi_q),
        .acc_lo_i  (acc_lo_q),
        .operand_i (opnd_q),
        .op_i      (op_q),
        .acc_hi_o  (core_hi),
        .acc_lo_o  (core_lo),
        .q_bit_o   (core_qbit)
    );

    assign iter_lo = core_lo | WIDTH'(core_qbit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            op_q     <= OP_MUL;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            sgn_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
`ifdef MULDIV_SIGNED_EN
            sgn_q    <= sgn_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
`endif
        end
    end

    // HI/LO are only written on the final step, so they never expose partial results.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
`ifdef MULDIV_SIGNED_EN
        sgn_d    = sgn_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    acc_hi_d = '0;
                    op_d     = op[0];
                    acc_lo_d = (op[0] == OP_MUL) ? b_mag : a_mag;
                    opnd_d   = (op[0] == OP_MUL) ? a_mag : b_mag;
`ifdef MULDIV_SIGNED_EN
                    sgn_d    = op[OP_SIGNED_BIT];
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = a_neg;
`endif
                end
            end
            RUN: begin
                acc_hi_d = core_hi;
                acc_lo_d = iter_lo;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    hi_d    = core_hi[WIDTH-1:0];
                    lo_d    = iter_lo;
`ifdef MULDIV_SIGNED_EN
                    if (sgn_q) begin
                        state_d = FIX;
                        done_d  = 1'b0;
                        hi_d    = hi_q;
                        lo_d    = lo_q;
                    end
`endif
                end
            end
`ifdef MULDIV_SIGNED_EN
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (op_q == OP_MUL) begin
                    {hi_d, lo_d} = neg_lo_q ? -prod : prod;
                end else begin
                    lo_d = neg_lo_q ? -acc_lo_q : acc_lo_q;
                    hi_d = neg_hi_q ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign stall = busy & (start | mf_req);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller for the HI/LO multiply/divide resource used by the MIPS datapath (multu, divu, mfhi, mflo).
- Accepts one operation from the control unit and iterates it one bit per cycle (shift-add multiply, restoring divide).
- Owns the HI/LO registers.
- Raises a stall to the datapath when a new mul/div or an HI/LO read arrives while an operation is still in flight.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH each; iteration count = WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  control unit issues mul/div this cycle.
- op  in  2  op[0]: 0 = multiply, 1 = divide; op[1]: signed (used only with MULDIV_SIGNED_EN).
- src_a  in  WIDTH  multiplicand / dividend (rs).
- src_b  in  WIDTH  multiplier / divisor (rt).
- mf_req  in  1  datapath is executing mfhi/mflo this cycle.
- stall  out  1  hold PC and the instruction in the datapath.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse: HI/LO just updated.
- hi  out  WIDTH  HI register: product upper half, or remainder.
- lo  out  WIDTH  LO register: product lower half, or quotient.

Behaviour:
- Reset (rst = 0, async): state IDLE, counter 0, all working registers 0. Outputs: hi = 0, lo = 0, busy = 0, done = 0, stall = 0.
- States: IDLE, RUN, FIX (FIX exists only with the macro).
- IDLE: start = 1 latches src_a, src_b and op, clears the accumulator and counter, then goes to RUN. start = 0 stays in IDLE.
- RUN: one iteration per cycle; counter increments.
  - Multiply: if the multiplier LSB is 1, add the multiplicand into the upper accumulator; then shift the 2×WIDTH accumulator right by 1, carry-in included. Accumulator width is WIDTH+1 to keep the carry.
  - Divide: shift {remainder, quotient} left by 1; trial-subtract the divisor from the remainder; if non-negative, keep the difference and set quotient LSB = 1.
  - After WIDTH iterations: write hi/lo, then go to IDLE (or to FIX).
- Timing: start sampled at edge ending cycle N.
  - busy = 1 in cycles N+1 .. N+WIDTH.
  - hi/lo written at the edge ending N+WIDTH.
  - done = 1 and busy = 0 in cycle N+WIDTH+1.
- hi/lo hold their previous values for the whole operation and never show partial results.
- stall = busy & (start | mf_req), combinational.
  - start while busy is not accepted; the datapath re-presents it after stall drops.
  - Only one operation is in flight at a time.
- start in the cycle done is high: accepted normally; no bubble needed.
- mf_req in the cycle done is high: no stall; hi/lo already hold the new result.
- Divide by zero: no trap; same latency. Result lo = all ones, hi = dividend (the natural restoring result).
- Multiply by zero: full latency; no early exit.
- rst asserted mid-operation: abort immediately; hi/lo go to 0 and no done pulse is produced.
- op is ignored when start = 0. src_a, src_b and op may change freely after acceptance.

Optional Feature:
- MULDIV_SIGNED_EN defined:
  - op[1] = 1 selects mult/div: operands are converted to magnitudes on acceptance.
  - The FIX state applies sign correction. Product is negated if the signs differ; quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Signed ops: busy N+1 .. N+WIDTH+1; done in N+WIDTH+2.
  - Unsigned ops skip FIX and keep the original latency.
- Not defined: op[1] is ignored, all operations are unsigned, and the FIX state does not exist.

Decomposition:
- Package muldiv_pkg:
  - op encodings OP_MUL = 1'b0 and OP_DIV = 1'b1, plus the signed-bit position.
  - State enum {IDLE, RUN, FIX}.
  - Default WIDTH.
  - Counter width, derived as $clog2(WIDTH+1).
- Sub-module muldiv_iter_core: purely combinational single-iteration step. Takes the accumulator, operand and op; returns the next accumulator and quotient bit.
- The sequencer keeps the FSM, counter, HI/LO and stall logic.

Test Plan:
- Multiply 0xFFFFFFFF × 0xFFFFFFFF, start at cycle 0 → done at cycle 33; hi = 0xFFFFFFFE, lo = 0x00000001; hi/lo unchanged in cycles 1–32.
- Divide 100 / 7 → hi = 2, lo = 14. Divide 5 / 0 → hi = 5, lo = 0xFFFFFFFF; same 33-cycle latency.
- mf_req in cycle 10 of a multiply → stall = 1 until cycle 33, stall = 0 in cycle 33. A second start at cycle 5 → stall held, then accepted at cycle 33 with done = 1; the back-to-back result is correct.
- rst low at cycle 15 of a divide → hi = lo = 0, busy = 0 immediately; no done pulse; the next op runs normally.
- MULDIV_SIGNED_EN: mult −3 × 5 → hi = 0xFFFFFFFF, lo = 0xFFFFFFF1; div −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; done at cycle 34. Without the macro, op = 2'b10 gives the unsigned result.
